status_flag_unit: RTL and testbench
===================================

// Module: status_flag_unit
// PURPOSE
//  Registered NZCV status unit, successor to the combinational flag generator. Width-parametrised,
//  S-gated flag capture, direct flag write, condition-code evaluation, and a DEPTH-entry save/restore
//  stack for exception entry/exit. Sits between ALU result/carry/overflow and branch/predication logic.
// PARAMETERS
//  WIDTH        32       ALU result width; N and Z are derived over this width
//  DEPTH        4        flag save-stack entries (>=1)
//  RESET_FLAGS  4'b0000  flag value loaded on reset, {N,Z,C,V}
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous active-high reset
//  s_en         in   1      set-flags strobe; capture ALU flags this cycle
//  result       in   WIDTH  ALU result
//  carry        in   1      ALU carry-out
//  overflow     in   1      ALU signed overflow
//  flag_we      in   1      direct flag write (MSR-style)
//  flag_wdata   in   4      direct write value {N,Z,C,V}
//  push         in   1      save current flag onto stack
//  pop          in   1      restore flag from top of stack
//  cond         in   4      condition code to evaluate
//  flag         out  4      registered flags {N,Z,C,V}
//  cond_pass    out  1      cond evaluated against registered flag
//  stack_full   out  1      stack holds DEPTH entries
//  stack_empty  out  1      stack holds 0 entries
//  stack_err    out  1      one-cycle pulse: illegal push/pop
// BEHAVIOUR
//  - Reset (async, any time): flag=RESET_FLAGS, stack count=0, stack_empty=1, stack_full=0, stack_err=0.
//    Stack entry contents are don't-care after reset.
//  - ALU capture: N=result[WIDTH-1], Z=(result==0) over all WIDTH bits, C=carry, V=overflow.
//    Visible on flag one cycle after s_en is sampled high; s_en=0 holds flag.
//  - Flag next-state priority: valid pop > flag_we > s_en > hold.
//  - Push writes the pre-update flag (the value visible this cycle), so push+s_en in the same
//    cycle saves the old flag and loads the new one. count+1 after the edge.
//  - Push while full: ignored (contents and count unchanged), stack_err=1 for one cycle.
//  - Pop while empty: ignored, stack_err=1; lower-priority flag_we/s_en still apply.
//  - Push and pop in the same cycle: both ignored, stack_err=1; flag_we/s_en still apply.
//  - LIFO order; count wraps never (saturating by rule above); stack_full/empty are registered from count.
//  - cond_pass is combinational from the registered flag (zero latency vs flag):
//    0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V |
//    8 HI C&!Z | 9 LS !C|Z | A GE N==V | B LT N!=V | C GT !Z&(N==V) | D LE Z|(N!=V) | E AL 1 | F NV 0
//  - stack_err is registered, high exactly the cycle after the offending request, else 0.
// CONFIGURATION
//  STICKY_OVF_EN defined: adds ports q_clr (in, 1) and q_flag (out, 1). q_flag sets on any cycle
//    with s_en=1 and overflow=1; stays set until q_clr sampled high; set wins over q_clr in the same
//    cycle. Reset -> 0. q_flag is not affected by flag_we, push, or pop.
//  STICKY_OVF_EN undefined: q_clr/q_flag ports and logic absent; all other behaviour identical.
// TESTING (WIDTH=32, DEPTH=2)
//  1 Reset: rst pulse -> flag=4'b0000, stack_empty=1, stack_full=0; cond=4'hE -> cond_pass=1,
//    cond=4'hF -> cond_pass=0.
//  2 Capture: s_en=1, result=32'h0, carry=0, overflow=1 -> next cycle flag=4'b0101, cond=0 pass=1;
//    then s_en=0, result=32'h8000_0000 -> flag stays 4'b0101.
//  3 Signed conds: s_en=1, result=32'h8000_0000, carry=1, overflow=1 -> flag=4'b1011;
//    cond=A pass=1, cond=C pass=1, cond=B pass=0, cond=8 pass=1.
//  4 Stack: flag=4'b1011, push; s_en result=32'h1 c=0 v=0 -> flag=4'b0000; pop -> flag=4'b1011,
//    stack_empty=1. Three pushes -> stack_full=1 after 2nd, stack_err=1 one cycle after 3rd.
//    Pop on empty with flag_we=1, flag_wdata=4'b0010 -> flag=4'b0010, stack_err=1; push+pop same cycle ->
//    count unchanged, stack_err=1.
//  5 Async reset mid-operation: with count=1, flag=4'b1011, assert rst between edges -> flag=4'b0000
//    and stack_empty=1 immediately, before next clk edge.
//  6 STICKY_OVF_EN: s_en with overflow=1 then s_en with overflow=0 -> V=0, q_flag=1;
//    q_clr=1 -> q_flag=0; q_clr=1 with s_en&overflow -> q_flag=1.

Source files
------------

// File: rtl/status_flag_unit.sv
// Registered NZCV status unit: S-gated ALU flag capture, direct write, condition evaluation, flag save stack.
// Latency: flag/stack status/stack_err update one cycle after the request; cond_pass is combinational from flag.
// Backpressure: none; illegal stack requests are dropped and flagged by a one-cycle stack_err pulse.
// Optional feature: define STICKY_OVF_EN to add the sticky overflow flag (q_clr in, q_flag out).
module status_flag_unit #(
    parameter int         WIDTH       = 32,
    parameter int         DEPTH       = 4,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_en,
    input  logic [WIDTH-1:0] result,
    input  logic             carry,
    input  logic             overflow,
    input  logic             flag_we,
    input  logic [3:0]       flag_wdata,
    input  logic             push,
    input  logic             pop,
    input  logic [3:0]       cond,
`ifdef STICKY_OVF_EN
    input  logic             q_clr,
    output logic             q_flag,
`endif
    output logic [3:0]       flag,
    output logic             cond_pass,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [3:0]    flag_q, flag_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, empty_q, err_q, err_d;
    logic [3:0]    stk_q [DEPTH];
    logic [3:0]    top_flag;
    logic          at_full, at_empty, push_ok, pop_ok;
    logic          n_f, z_f, c_f, v_f;

    assign at_full  = (cnt_q == CW'(DEPTH));
    assign at_empty = (cnt_q == '0);
    // Simultaneous push and pop is illegal, so neither is accepted in that case.
    assign push_ok  = push & ~pop & ~at_full;
    assign pop_ok   = pop & ~push & ~at_empty;

    // Classify illegal stack requests for the registered error pulse.
    always_comb begin
        err_d = 1'b0;
        if (push && pop)
            err_d = 1'b1;
        else if (push && at_full)
            err_d = 1'b1;
        else if (pop && at_empty)
            err_d = 1'b1;
    end

    // Select the top-of-stack entry (slot count-1) for restore.
    always_comb begin
        top_flag = flag_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt_q == CW'(i + 1))
                top_flag = stk_q[i];
        end
    end

    // Flag next state: accepted pop beats direct write beats ALU capture beats hold.
    always_comb begin
        flag_d = flag_q;
        if (pop_ok)
            flag_d = top_flag;
        else if (flag_we)
            flag_d = flag_wdata;
        else if (s_en)
            flag_d = {result[WIDTH-1], (result == '0), carry, overflow};
    end

    // Stack occupancy moves only on accepted requests, so it saturates at both ends.
    always_comb begin
        cnt_d = cnt_q;
        if (push_ok)
            cnt_d = cnt_q + CW'(1);
        else if (pop_ok)
            cnt_d = cnt_q - CW'(1);
    end

    // Flag, occupancy, registered full/empty and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q  <= RESET_FLAGS;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
            err_q   <= err_d;
        end
    end

    // Stack storage saves the flag visible this cycle; contents need no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && (cnt_q == CW'(i)))
                stk_q[i] <= flag_q;
        end
    end

    assign n_f = flag_q[3];
    assign z_f = flag_q[2];
    assign c_f = flag_q[1];
    assign v_f = flag_q[0];

    // Condition-code evaluation against the registered flags.
    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            4'h0: cond_pass = z_f;
            4'h1: cond_pass = ~z_f;
            4'h2: cond_pass = c_f;
            4'h3: cond_pass = ~c_f;
            4'h4: cond_pass = n_f;
            4'h5: cond_pass = ~n_f;
            4'h6: cond_pass = v_f;
            4'h7: cond_pass = ~v_f;
            4'h8: cond_pass = c_f & ~z_f;
            4'h9: cond_pass = ~c_f | z_f;
            4'hA: cond_pass = (n_f == v_f);
            4'hB: cond_pass = (n_f != v_f);
            4'hC: cond_pass = ~z_f & (n_f == v_f);
            4'hD: cond_pass = z_f | (n_f != v_f);
            4'hE: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    assign flag        = flag_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign stack_err   = err_q;

`ifdef STICKY_OVF_EN
    logic q_flag_q, q_flag_d;

    // Sticky overflow: a new overflow capture wins over a clear in the same cycle.
    always_comb begin
        q_flag_d = q_flag_q;
        if (s_en && overflow)
            q_flag_d = 1'b1;
        else if (q_clr)
            q_flag_d = 1'b0;
    end

    // Sticky overflow register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_flag_q <= 1'b0;
        else
            q_flag_q <= q_flag_d;
    end

    assign q_flag = q_flag_q;
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit at WIDTH=32, DEPTH=2.
// Expectations are queued with each stimulus row and checked one cycle later.
// Define STICKY_OVF_EN to exercise the sticky overflow feature as well.
module tb_status_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_en;
    logic [31:0] result;
    logic        carry;
    logic        overflow;
    logic        flag_we;
    logic [3:0]  flag_wdata;
    logic        push;
    logic        pop;
    logic [3:0]  cond;
    logic        q_clr;
    logic        q_flag;
    logic [3:0]  flag;
    logic        cond_pass;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       name;
        logic        s_en;
        logic [31:0] result;
        logic        carry;
        logic        ovf;
        logic        we;
        logic [3:0]  wdata;
        logic        push;
        logic        pop;
        logic [3:0]  cond;
        logic        qclr;
        logic [3:0]  e_flag;
        logic        e_full;
        logic        e_empty;
        logic        e_err;
        logic        e_pass;
        logic        e_q;
    } row_t;

    row_t exp_q[$];
    row_t tbl[$];

    always #5 clk = ~clk;

    status_flag_unit #(.WIDTH(32), .DEPTH(2), .RESET_FLAGS(4'b0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_en       (s_en),
        .result     (result),
        .carry      (carry),
        .overflow   (overflow),
        .flag_we    (flag_we),
        .flag_wdata (flag_wdata),
        .push       (push),
        .pop        (pop),
        .cond       (cond),
`ifdef STICKY_OVF_EN
        .q_clr      (q_clr),
        .q_flag     (q_flag),
`endif
        .flag       (flag),
        .cond_pass  (cond_pass),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

`ifndef STICKY_OVF_EN
    assign q_flag = 1'b0;
`endif

    function automatic row_t mk(string name, logic se, logic [31:0] res, logic c, logic v,
                                logic we, logic [3:0] wd, logic pu, logic po, logic [3:0] cd,
                                logic qc, logic [3:0] ef, logic efu, logic eem, logic eer,
                                logic epa, logic eq);
        row_t r;
        r.name = name; r.s_en = se; r.result = res; r.carry = c; r.ovf = v;
        r.we = we; r.wdata = wd; r.push = pu; r.pop = po; r.cond = cd; r.qclr = qc;
        r.e_flag = ef; r.e_full = efu; r.e_empty = eem; r.e_err = eer; r.e_pass = epa; r.e_q = eq;
        return r;
    endfunction

    task automatic drive(input row_t r);
        s_en = r.s_en; result = r.result; carry = r.carry; overflow = r.ovf;
        flag_we = r.we; flag_wdata = r.wdata; push = r.push; pop = r.pop;
        cond = r.cond; q_clr = r.qclr;
    endtask

    task automatic idle_inputs();
        s_en = 0; result = '0; carry = 0; overflow = 0; flag_we = 0; flag_wdata = '0;
        push = 0; pop = 0; cond = 4'hE; q_clr = 0;
    endtask

    task automatic test_reset();
        row_t e;
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back(mk("reset_al", 0, 0, 0, 0, 0, 0, 0, 0, 4'hE, 0, 4'b0000, 0, 1, 0, 1, 0));
        cond = 4'hE;
        #1 e = exp_q.pop_front();
        n_cmp++; if (flag !== e.e_flag) begin n_bad++; $display("FAIL %s flag got %b want %b", e.name, flag, e.e_flag); end
        n_cmp++; if (stack_empty !== e.e_empty) begin n_bad++; $display("FAIL %s empty got %b want %b", e.name, stack_empty, e.e_empty); end
        n_cmp++; if (stack_full !== e.e_full) begin n_bad++; $display("FAIL %s full got %b want %b", e.name, stack_full, e.e_full); end
        n_cmp++; if (stack_err !== e.e_err) begin n_bad++; $display("FAIL %s err got %b want %b", e.name, stack_err, e.e_err); end
        n_cmp++; if (cond_pass !== e.e_pass) begin n_bad++; $display("FAIL %s pass got %b want %b", e.name, cond_pass, e.e_pass); end
        n_cmp++; if (q_flag !== e.e_q) begin n_bad++; $display("FAIL %s q_flag got %b want %b", e.name, q_flag, e.e_q); end
        exp_q.push_back(mk("reset_nv", 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 4'b0000, 0, 1, 0, 0, 0));
        cond = 4'hF;
        #1 e = exp_q.pop_front();
        n_cmp++; if (cond_pass !== e.e_pass) begin n_bad++; $display("FAIL %s pass got %b want %b", e.name, cond_pass, e.e_pass); end
        @(posedge clk); #1;
    endtask

    // Runs the queued table: each row is driven, its expectation queued, then checked after the edge.
    task automatic run_table(input string tag);
        row_t e;
        foreach (tbl[i]) begin
            drive(tbl[i]);
            exp_q.push_back(tbl[i]);
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (flag !== e.e_flag) begin n_bad++; $display("FAIL %s/%s flag got %b want %b", tag, e.name, flag, e.e_flag); end
            n_cmp++; if (stack_full !== e.e_full) begin n_bad++; $display("FAIL %s/%s full got %b want %b", tag, e.name, stack_full, e.e_full); end
            n_cmp++; if (stack_empty !== e.e_empty) begin n_bad++; $display("FAIL %s/%s empty got %b want %b", tag, e.name, stack_empty, e.e_empty); end
            n_cmp++; if (stack_err !== e.e_err) begin n_bad++; $display("FAIL %s/%s err got %b want %b", tag, e.name, stack_err, e.e_err); end
            n_cmp++; if (cond_pass !== e.e_pass) begin n_bad++; $display("FAIL %s/%s pass got %b want %b", tag, e.name, cond_pass, e.e_pass); end
`ifdef STICKY_OVF_EN
            n_cmp++; if (q_flag !== e.e_q) begin n_bad++; $display("FAIL %s/%s q_flag got %b want %b", tag, e.name, q_flag, e.e_q); end
`endif
        end
        tbl.delete();
        idle_inputs();
    endtask

    task automatic test_capture();
        //                name       se res            c  v  we wd  pu po cd    qc flag     fu em er pa q
        tbl.push_back(mk("cap_zv",   1, 32'h0,         0, 1, 0, 0, 0, 0, 4'h0, 0, 4'b0101, 0, 1, 0, 1, 1));
        tbl.push_back(mk("hold",     0, 32'h8000_0000, 1, 0, 0, 0, 0, 0, 4'h6, 0, 4'b0101, 0, 1, 0, 1, 1));
        tbl.push_back(mk("hold_ne",  0, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 4'h1, 0, 4'b0101, 0, 1, 0, 0, 1));
        tbl.push_back(mk("cap_c",    1, 32'h0000_0010, 1, 0, 0, 0, 0, 0, 4'h2, 0, 4'b0010, 0, 1, 0, 1, 1));
        run_table("capture");
    endtask

    task automatic test_signed_conds();
        tbl.push_back(mk("cap_nv",   1, 32'h8000_0000, 1, 1, 0, 0, 0, 0, 4'hA, 0, 4'b1011, 0, 1, 0, 1, 1));
        tbl.push_back(mk("gt",       0, 32'h0,         0, 0, 0, 0, 0, 0, 4'hC, 0, 4'b1011, 0, 1, 0, 1, 1));
        tbl.push_back(mk("lt",       0, 32'h0,         0, 0, 0, 0, 0, 0, 4'hB, 0, 4'b1011, 0, 1, 0, 0, 1));
        tbl.push_back(mk("hi",       0, 32'h0,         0, 0, 0, 0, 0, 0, 4'h8, 0, 4'b1011, 0, 1, 0, 1, 1));
        tbl.push_back(mk("ls",       0, 32'h0,         0, 0, 0, 0, 0, 0, 4'h9, 0, 4'b1011, 0, 1, 0, 0, 1));
        tbl.push_back(mk("le",       0, 32'h0,         0, 0, 0, 0, 0, 0, 4'hD, 0, 4'b1011, 0, 1, 0, 0, 1));
        tbl.push_back(mk("mi",       0, 32'h0,         0, 0, 0, 0, 0, 0, 4'h4, 0, 4'b1011, 0, 1, 0, 1, 1));
        run_table("signed");
    endtask

    task automatic test_stack();
        tbl.push_back(mk("push1",    0, 32'h0,         0, 0, 0, 0,       1, 0, 4'hE, 0, 4'b1011, 0, 0, 0, 1, 1));
        tbl.push_back(mk("cap_one",  1, 32'h1,         0, 0, 0, 0,       0, 0, 4'h0, 0, 4'b0000, 0, 0, 0, 0, 1));
        tbl.push_back(mk("pop1",     0, 32'h0,         0, 0, 0, 0,       0, 1, 4'hE, 0, 4'b1011, 0, 1, 0, 1, 1));
        tbl.push_back(mk("push_we",  0, 32'h0,         0, 0, 1, 4'b0110, 1, 0, 4'hE, 0, 4'b0110, 0, 0, 0, 1, 1));
        tbl.push_back(mk("push2",    0, 32'h0,         0, 0, 0, 0,       1, 0, 4'hE, 0, 4'b0110, 1, 0, 0, 1, 1));
        tbl.push_back(mk("push_ful", 1, 32'h8000_0000, 0, 0, 0, 0,       1, 0, 4'hE, 0, 4'b1000, 1, 0, 1, 1, 1));
        tbl.push_back(mk("idle",     0, 32'h0,         0, 0, 0, 0,       0, 0, 4'hE, 0, 4'b1000, 1, 0, 0, 1, 1));
        tbl.push_back(mk("pop_a",    0, 32'h0,         0, 0, 0, 0,       0, 1, 4'hE, 0, 4'b0110, 0, 0, 0, 1, 1));
        tbl.push_back(mk("pop_b",    0, 32'h0,         0, 0, 0, 0,       0, 1, 4'hE, 0, 4'b1011, 0, 1, 0, 1, 1));
        tbl.push_back(mk("pop_emp",  1, 32'h0,         0, 1, 1, 4'b0010, 0, 1, 4'hE, 0, 4'b0010, 0, 1, 1, 1, 1));
        tbl.push_back(mk("push3",    0, 32'h0,         0, 0, 0, 0,       1, 0, 4'hE, 0, 4'b0010, 0, 0, 0, 1, 1));
        tbl.push_back(mk("push_pop", 1, 32'h1,         1, 1, 0, 0,       1, 1, 4'hE, 0, 4'b0011, 0, 0, 1, 1, 1));
        tbl.push_back(mk("pop_last", 0, 32'h0,         0, 0, 0, 0,       0, 1, 4'hE, 0, 4'b0010, 0, 1, 0, 1, 1));
        run_table("stack");
    endtask

    task automatic test_async_reset();
        row_t e;
        tbl.push_back(mk("set_1011", 0, 32'h0, 0, 0, 1, 4'b1011, 0, 0, 4'hE, 0, 4'b1011, 0, 1, 0, 1, 1));
        tbl.push_back(mk("push_one", 0, 32'h0, 0, 0, 0, 0,       1, 0, 4'hE, 0, 4'b1011, 0, 0, 0, 1, 1));
        run_table("arst_pre");
        #3 rst = 1'b1;
        exp_q.push_back(mk("arst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 4'hE, 0, 4'b0000, 0, 1, 0, 1, 0));
        #1 e = exp_q.pop_front();
        n_cmp++; if (flag !== e.e_flag) begin n_bad++; $display("FAIL %s flag got %b want %b", e.name, flag, e.e_flag); end
        n_cmp++; if (stack_empty !== e.e_empty) begin n_bad++; $display("FAIL %s empty got %b want %b", e.name, stack_empty, e.e_empty); end
        n_cmp++; if (stack_full !== e.e_full) begin n_bad++; $display("FAIL %s full got %b want %b", e.name, stack_full, e.e_full); end
        n_cmp++; if (q_flag !== e.e_q) begin n_bad++; $display("FAIL %s q_flag got %b want %b", e.name, q_flag, e.e_q); end
        @(posedge clk); #1 rst = 1'b0;
        // After reset the stack must be empty again: a pop is an error and leaves flag alone.
        tbl.push_back(mk("pop_post", 0, 32'h0, 0, 0, 0, 0, 0, 1, 4'hE, 0, 4'b0000, 0, 1, 1, 1, 0));
        run_table("arst_post");
    endtask

`ifdef STICKY_OVF_EN
    task automatic test_sticky();
        tbl.push_back(mk("ovf_set",  1, 32'h5, 0, 1, 0, 0,       0, 0, 4'hE, 0, 4'b0001, 0, 1, 0, 1, 1));
        tbl.push_back(mk("ovf_keep", 1, 32'h5, 0, 0, 0, 0,       0, 0, 4'h6, 0, 4'b0000, 0, 1, 0, 0, 1));
        tbl.push_back(mk("we_push",  0, 32'h0, 0, 0, 1, 4'b0000, 1, 0, 4'hE, 0, 4'b0000, 0, 0, 0, 1, 1));
        tbl.push_back(mk("pop_keep", 0, 32'h0, 0, 0, 0, 0,       0, 1, 4'hE, 0, 4'b0000, 0, 1, 0, 1, 1));
        tbl.push_back(mk("clr",      0, 32'h0, 0, 0, 0, 0,       0, 0, 4'hE, 1, 4'b0000, 0, 1, 0, 1, 0));
        tbl.push_back(mk("set_wins", 1, 32'h0, 0, 1, 0, 0,       0, 0, 4'hE, 1, 4'b0101, 0, 1, 0, 1, 1));
        run_table("sticky");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_capture();
        test_signed_conds();
        test_stack();
        test_async_reset();
`ifdef STICKY_OVF_EN
        test_sticky();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
